cube_move_scheduler: RTL and testbench
======================================

// Module: cube_move_scheduler
// PURPOSE
//  Turns USB HID keycodes from the NIOS II keycode PIO into cube-rotation commands and
//  sequences them into the cube-state/render datapath, one move at a time.
//  Captures presses, maps them to moves, queues them in a FIFO, and issues each move
//  with a valid/ready handshake. It then waits for move_done before issuing the next.
// PARAMETERS
//  QDEPTH   8        move FIFO depth (power of 2, >=2)
//  TIMEOUT  2000000  cycles to wait for move_done before aborting (>=1)
// PORTS
//  clk_clk        in   1   system clock (50 MHz)
//  reset_reset_n  in   1   asynchronous, active-low reset
//  keycode        in   8   HID keycode from SoC PIO; 0 = no key
//  enable         in   1   1 = issuing allowed; 0 = hold queue (capture continues)
//  move_ready     in   1   datapath accepts move this cycle
//  move_done      in   1   1-cycle pulse: datapath finished current move
//  move_valid     out  1   move_code valid, held until move_ready
//  move_code      out  4   {prime, face[2:0]}; face U0 D1 L2 R3 F4 B5
//  busy           out  1   state != IDLE
//  q_count        out  $clog2(QDEPTH+1)  queued moves
//  prime_mode     out  1   current prime (counter-clockwise) toggle
//  overflow       out  1   sticky: a move was dropped on full queue
//  fault          out  1   sticky: move_done timeout occurred
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; queue empty; prime_mode 0; kc_q 0.
//  Capture: kc_q <= keycode each cycle; a press is when keycode!=0 and keycode!=kc_q.
//   Nonzero->different nonzero counts as a press; a held key counts once.
//  Map (on press): 0x18 U, 0x07 D, 0x0F L, 0x15 R, 0x09 F, 0x05 B ->
//   enqueue {prime_mode, face}. Other codes:
//   0x2C (space) toggles prime_mode; no enqueue.
//   0x2A (backspace) = flush: empties queue and clears overflow and fault.
//   Any other code is ignored.
//  Enqueue is registered; q_count rises on the edge after the press is detected.
//  Full queue: the press is dropped and overflow is set. Exception: a pop on the same
//   cycle frees a slot, so the press is accepted.
//  Flush and enqueue on the same cycle: flush wins and the press is discarded.
//  Flush never affects a move already popped (ISSUE/WAIT_DONE).
//  FSM:
//   IDLE: if enable && q_count!=0 -> pop head into move_code, go to ISSUE.
//   ISSUE: move_valid=1; move_code stable. On move_ready, drop valid -> WAIT_DONE.
//   WAIT_DONE: on move_done -> IDLE. If the counter reaches TIMEOUT, set fault -> IDLE.
//  move_ready outside ISSUE is ignored. move_done outside WAIT_DONE is ignored.
//  enable=0 only blocks IDLE->ISSUE; an in-flight move completes normally.
//  Latency: a press change at edge E0 is enqueued at E1 and popped at E2.
//   move_valid is high after E2, so the minimum is 3 edges.
//  Back-to-back: the next move is popped 1 cycle after move_done (IDLE->ISSUE).
//  FIFO pointers wrap modulo QDEPTH. q_count saturates at QDEPTH.
//  The timeout counter clears on entry to WAIT_DONE.
//  Reset mid-operation: immediate return to reset state; the in-flight move is lost.
// TESTING
//  1 Press 0x18, release. move_ready=1, done 5 cyc later -> move_code=0x0, valid 1 cycle,
//    busy high, then q_count 0.
//  2 Press 0x2C then 0x15 -> prime_mode=1, move_code=0xB.
//    Hold 0x15 100 cycles -> only one move queued.
//  3 enable=0, press 9 mapped keys with QDEPTH=8 -> q_count=8, overflow=1.
//    Press 0x2A -> q_count=0, overflow=0.
//  4 Full queue, enqueue on the same cycle as pop -> q_count stays 8, overflow stays 0.
//  5 move_ready low 10 cycles in ISSUE -> valid held, move_code constant.
//    Withhold done for TIMEOUT=16 -> fault=1, FSM to IDLE.
//  6 Assert reset_reset_n=0 in WAIT_DONE with 3 queued -> all outputs 0, q_count 0,
//    IDLE on the next clk.

Source files
------------

// File: rtl/cube_move_scheduler_if.sv
// Cube move scheduler bus: keycode capture inputs, datapath handshake and status.
// master = scheduler side, slave = SoC/datapath side.
interface cube_move_scheduler_if #(
  parameter int unsigned QDEPTH = 8
);
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [7:0]    keycode;
  logic          enable;
  logic          move_ready;
  logic          move_done;
  logic          move_valid;
  logic [3:0]    move_code;
  logic          busy;
  logic [CW-1:0] q_count;
  logic          prime_mode;
  logic          overflow;
  logic          fault;

  modport master (
    input  keycode, enable, move_ready, move_done,
    output move_valid, move_code, busy, q_count, prime_mode, overflow, fault
  );

  modport slave (
    output keycode, enable, move_ready, move_done,
    input  move_valid, move_code, busy, q_count, prime_mode, overflow, fault
  );
endinterface

// File: rtl/cube_move_scheduler.sv
// Cube move scheduler: turns HID keycode presses into face-turn moves, queues
// them, and issues one move at a time to the cube datapath with a
// valid/ready handshake followed by a move_done wait (with timeout).
module cube_move_scheduler #(
  parameter int unsigned QDEPTH  = 8,
  parameter int unsigned TIMEOUT = 2000000
) (
  input logic                    clk_clk,
  input logic                    reset_reset_n,
  cube_move_scheduler_if.master  bus
);
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [7:0]    kc_q;
  logic          prime_q,  prime_d;
  logic          ovf_q,    ovf_d;
  logic          flt_q,    flt_d;
  logic [1:0]    state_q,  state_d;
  logic [3:0]    code_q,   code_d;
  logic [TW-1:0] tmr_q,    tmr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [PW-1:0] wr_q,     wr_d;
  logic [PW-1:0] rd_q,     rd_d;
  logic [3:0]    mem_q [QDEPTH];

  logic       press, is_move, flush, toggle;
  logic [2:0] face;
  logic       full, pop, push_req, push, drop, timeout_hit;

  // Keycode decode: edge-detected press and key-to-face mapping
  always_comb begin
    press   = (bus.keycode != 8'h00) && (bus.keycode != kc_q);
    is_move = 1'b0;
    face    = 3'd0;
    case (bus.keycode)
      8'h18:   begin is_move = 1'b1; face = 3'd0; end
      8'h07:   begin is_move = 1'b1; face = 3'd1; end
      8'h0F:   begin is_move = 1'b1; face = 3'd2; end
      8'h15:   begin is_move = 1'b1; face = 3'd3; end
      8'h09:   begin is_move = 1'b1; face = 3'd4; end
      8'h05:   begin is_move = 1'b1; face = 3'd5; end
      default: begin is_move = 1'b0; face = 3'd0; end
    endcase
    flush    = press && (bus.keycode == 8'h2A);
    toggle   = press && (bus.keycode == 8'h2C);
    full     = (count_q == CW'(QDEPTH));
    pop      = (state_q == S_IDLE) && bus.enable && (count_q != '0);
    push_req = press && is_move && !flush;
    // A pop in the same cycle frees the slot the push needs.
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // Queue pointer/count next-state; flush clears everything not yet popped
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Issue FSM next-state with move_done timeout
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    tmr_d       = tmr_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          code_d  = mem_q[rd_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.move_ready) begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.move_done) begin
          state_d = S_IDLE;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky flags and prime toggle; a timeout in the flush cycle still sets fault
  always_comb begin
    prime_d = prime_q ^ toggle;
    ovf_d   = (ovf_q && !flush) || drop;
    flt_d   = (flt_q && !flush) || timeout_hit;
  end

  // State registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      kc_q    <= '0;
      prime_q <= 1'b0;
      ovf_q   <= 1'b0;
      flt_q   <= 1'b0;
      state_q <= S_IDLE;
      code_q  <= '0;
      tmr_q   <= '0;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      kc_q    <= bus.keycode;
      prime_q <= prime_d;
      ovf_q   <= ovf_d;
      flt_q   <= flt_d;
      state_q <= state_d;
      code_q  <= code_d;
      tmr_q   <= tmr_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Queue storage write
  always_ff @(posedge clk_clk) begin
    if (push) mem_q[wr_q] <= {prime_q, face};
  end

  assign bus.move_valid = (state_q == S_ISSUE);
  assign bus.move_code  = code_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.q_count    = count_q;
  assign bus.prime_mode = prime_q;
  assign bus.overflow   = ovf_q;
  assign bus.fault      = flt_q;
endmodule

// File: tb/tb_cube_move_scheduler.sv
// Bench for cube_move_scheduler: directed scenarios plus random keycode and
// datapath traffic, checked every cycle against a transaction-level model.
module tb_cube_move_scheduler;
  localparam int unsigned QDEPTH  = 8;
  localparam int unsigned TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cube_move_scheduler_if #(.QDEPTH(QDEPTH)) bus ();

  cube_move_scheduler #(.QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Face index of a keycode, or -1 when the key is not a move key
  function automatic int face_of(input logic [7:0] k);
    case (k)
      8'h18: return 0;
      8'h07: return 1;
      8'h0F: return 2;
      8'h15: return 3;
      8'h09: return 4;
      8'h05: return 5;
      default: return -1;
    endcase
  endfunction

  // Reference model: a queue of pending moves plus the phase of the move in flight
  // (0 = none, 1 = offered to datapath, 2 = waiting for done).
  bit [3:0]   mq[$];
  bit [7:0]   m_kc;
  bit         m_prime, m_ovf, m_flt;
  bit [3:0]   m_code;
  int         m_ph, m_wcnt;
  bit         m_press;
  int         m_ph0, m_face;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_kc = 0; m_prime = 0; m_ovf = 0; m_flt = 0;
      m_code = 0; m_ph = 0; m_wcnt = 0;
    end else begin
      m_press = (bus.keycode != 0) && (bus.keycode != m_kc);
      m_face  = face_of(bus.keycode);
      m_ph0   = m_ph;
      if (m_ph0 == 0 && bus.enable && mq.size() != 0) begin
        m_code = mq.pop_front();
        m_ph   = 1;
      end
      if (m_press && bus.keycode == 8'h2A) begin
        mq.delete();
        m_ovf = 0;
        m_flt = 0;
      end else if (m_press && m_face >= 0) begin
        if (mq.size() < QDEPTH) mq.push_back({m_prime, 3'(m_face)});
        else m_ovf = 1;
      end
      if (m_press && bus.keycode == 8'h2C) m_prime = !m_prime;
      if (m_ph0 == 1 && bus.move_ready) begin
        m_ph   = 2;
        m_wcnt = 0;
      end else if (m_ph0 == 2) begin
        if (bus.move_done) m_ph = 0;
        else begin
          m_wcnt++;
          if (m_wcnt == TIMEOUT) begin
            m_flt = 1;
            m_ph  = 0;
          end
        end
      end
      m_kc = bus.keycode;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("move_valid", int'(bus.move_valid), int'(m_ph == 1));
    chk("busy",       int'(bus.busy),       int'(m_ph != 0));
    chk("q_count",    int'(bus.q_count),    mq.size());
    chk("prime_mode", int'(bus.prime_mode), int'(m_prime));
    chk("overflow",   int'(bus.overflow),   int'(m_ovf));
    chk("fault",      int'(bus.fault),      int'(m_flt));
    if (m_ph == 1) chk("move_code", int'(bus.move_code), int'(m_code));
  end

  bit [7:0] keys [6] = '{8'h18, 8'h07, 8'h0F, 8'h15, 8'h09, 8'h05};

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input logic [7:0] k);
    bus.keycode = k;
    tick();
    bus.keycode = 8'h00;
    tick();
  endtask

  initial begin
    int r, hold;
    bus.keycode = 0; bus.enable = 0; bus.move_ready = 0; bus.move_done = 0;
    tick(3);
    chk("rst_q_count", int'(bus.q_count), 0);
    chk("rst_valid",   int'(bus.move_valid), 0);
    chk("rst_busy",    int'(bus.busy), 0);
    rst_n = 1'b1;
    tick();

    // U move: latency of press -> enqueue -> issue, then done
    bus.enable = 1;
    bus.keycode = 8'h18;
    tick();
    chk("lat_enq_q", int'(bus.q_count), 1);
    chk("lat_enq_valid", int'(bus.move_valid), 0);
    bus.keycode = 8'h00;
    tick();
    chk("lat_pop_valid", int'(bus.move_valid), 1);
    chk("lat_pop_code", int'(bus.move_code), 0);
    chk("lat_pop_q", int'(bus.q_count), 0);
    bus.move_ready = 1;
    tick();
    chk("t1_valid_drop", int'(bus.move_valid), 0);
    chk("t1_busy_wait", int'(bus.busy), 1);
    bus.move_ready = 0;
    tick(4);
    bus.move_done = 1;
    tick();
    bus.move_done = 0;
    chk("t1_idle", int'(bus.busy), 0);

    // Prime toggle and held key counting once
    tap(8'h2C);
    chk("t2_prime", int'(bus.prime_mode), 1);
    bus.enable = 0;
    bus.keycode = 8'h15;
    tick(100);
    chk("t2_held_once", int'(bus.q_count), 1);
    bus.keycode = 8'h00;
    bus.enable = 1;
    tick();
    chk("t2_code_Rp", int'(bus.move_code), 11);
    bus.move_ready = 1; tick(); bus.move_ready = 0;
    bus.move_done = 1;  tick(); bus.move_done = 0;
    tap(8'h2C);

    // Overflow on full queue, then flush
    bus.enable = 0;
    for (int i = 0; i < 9; i++) tap(keys[i % 6]);
    chk("t3_full", int'(bus.q_count), 8);
    chk("t3_ovf", int'(bus.overflow), 1);
    tap(8'h2A);
    chk("t3_flush_q", int'(bus.q_count), 0);
    chk("t3_flush_ovf", int'(bus.overflow), 0);

    // Push on a full queue in the same cycle as a pop
    for (int i = 0; i < 8; i++) tap(keys[i % 6]);
    bus.enable = 1;
    bus.keycode = 8'h07;
    tick();
    chk("t4_q_stays", int'(bus.q_count), 8);
    chk("t4_no_ovf", int'(bus.overflow), 0);
    chk("t4_valid", int'(bus.move_valid), 1);
    bus.enable = 0;
    bus.keycode = 8'h00;
    bus.move_ready = 1; tick(); bus.move_ready = 0;
    bus.move_done = 1;  tick(); bus.move_done = 0;
    tap(8'h2A);

    // Stall in ISSUE, then done timeout
    bus.enable = 1;
    tap(8'h09);
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_valid", int'(bus.move_valid), 1);
      chk("t5_hold_code", int'(bus.move_code), 4);
      tick();
    end
    bus.move_ready = 1; tick(); bus.move_ready = 0;
    tick(TIMEOUT - 1);
    chk("t5_pre_timeout", int'(bus.busy), 1);
    chk("t5_pre_fault", int'(bus.fault), 0);
    tick();
    chk("t5_fault", int'(bus.fault), 1);
    chk("t5_idle", int'(bus.busy), 0);
    tap(8'h2A);
    chk("t5_fault_clr", int'(bus.fault), 0);

    // Reset while waiting for done with moves queued
    bus.enable = 0;
    for (int i = 0; i < 4; i++) tap(keys[i]);
    bus.enable = 1; tick(); bus.enable = 0;
    bus.move_ready = 1; tick(); bus.move_ready = 0;
    chk("t6_q3", int'(bus.q_count), 3);
    chk("t6_busy", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_q", int'(bus.q_count), 0);
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_valid", int'(bus.move_valid), 0);
    chk("t6_rst_prime", int'(bus.prime_mode), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_after_busy", int'(bus.busy), 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n += hold) begin
      r = $urandom_range(0, 29);
      if (r < 8)       bus.keycode = 8'h00;
      else if (r < 20) bus.keycode = keys[r % 6];
      else if (r < 23) bus.keycode = 8'h2C;
      else if (r == 23) bus.keycode = 8'h2A;
      else             bus.keycode = 8'($urandom_range(1, 255));
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        bus.enable     = ($urandom_range(0, 7) != 0);
        bus.move_ready = $urandom_range(0, 1) != 0;
        bus.move_done  = ($urandom_range(0, 11) == 0);
        tick();
      end
    end
    bus.keycode = 0; bus.move_done = 0; bus.move_ready = 0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
